mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Single-port synchronous memory that answers the processor's memory address register. It accepts an address plus a read or write strobe from the control unit. It applies a programmable number of wait states, then completes the access with a one-cycle ready pulse. Read data is driven onto the shared bus through an enable qualifier.

Parameters:
ADDR_W, 8, address width; memory depth = 2**ADDR_W words.
DATA_W, 16, word width (opcode + address field of the bus).
WAIT_CYCLES, 2, wait states inserted before each access completes; legal range 0..15.
PROT_BASE, 8'hF0, lowest write-protected address (used only with MEM_WRPROT_EN).

Ports:
clk  input  1  clock; all state changes on the rising edge.
nrst  input  1  reset, synchronous, active-low.
address  input  ADDR_W  word address from the memory address register.
mem_rd  input  1  read request; sampled only in IDLE.
mem_wr  input  1  write request; sampled only in IDLE.
wr_data  input  DATA_W  write data; sampled together with the request.
rd_data  output  DATA_W  registered read data.
mem_bus_en  output  1  high while rd_data must be driven onto the bus.
mem_ready  output  1  one-cycle completion pulse.
mem_busy  output  1  high in every state except IDLE.
wr_err  output  1  write-protection violation pulse; constant 0 without MEM_WRPROT_EN.

Behaviour:
- Reset (nrst==0 at an edge):
  - state=IDLE; rd_data=0; mem_bus_en=0; mem_ready=0; mem_busy=0; wr_err=0; wait counter=0.
  - Memory array contents are not cleared.
- FSM states:
  - IDLE: at an edge with mem_rd or mem_wr high, latch address, wr_data and op. mem_wr has priority when both are high; the access is then a write.
    - WAIT_CYCLES==0: go directly to RESP.
    - Otherwise: go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: decrement the counter each edge. When the counter==0 at an edge, go to RESP.
  - RESP: lasts exactly one cycle; returns to IDLE at the next edge.
- Commit timing:
  - The memory write, or the rd_data update, happens on the same edge that enters RESP.
  - mem_ready=1 throughout RESP.
  - mem_bus_en=1 throughout RESP for reads only; 0 for writes.
- Latency: request sampled at edge E → RESP during the cycle after edge E+WAIT_CYCLES → IDLE again after edge E+WAIT_CYCLES+1.
- Throughput: the earliest next request is sampled at edge E+WAIT_CYCLES+2; one access per WAIT_CYCLES+2 cycles.
- Requests while busy: mem_rd/mem_wr in WAIT or RESP are ignored, not queued. Address and wr_data changes during WAIT have no effect.
- rd_data holds its last read value through writes and idle periods; it changes only on read commit or reset.
- mem_busy is registered with the state.
- Addresses cover the full 0..2**ADDR_W-1 range; there is no out-of-range case.
- Reset mid-access: reset in WAIT aborts the access and no write is committed. Synchronous reset takes priority over the commit edge.
- Read of a never-written location returns X in simulation; the bench must write before reading.

Optional Feature:
Macro MEM_WRPROT_EN.
- Defined: a write with latched address >= PROT_BASE is not committed. wr_err=1 during RESP alongside mem_ready, and the handshake timing is unchanged. Reads are unaffected.
- Undefined: all writes commit and wr_err is tied 0.

Test Plan:
- Reset then idle: nrst=0 for 2 cycles → rd_data=0, mem_ready=0, mem_busy=0, mem_bus_en=0.
- Write then read, WAIT_CYCLES=2:
  - Write 16'hA55A to address 8'h10 → mem_ready pulses exactly once, 3 cycles after the sampling edge.
  - Read of 8'h10 → rd_data=16'hA55A with mem_bus_en=1 for that one cycle only.
- Busy rejection and priority:
  - During WAIT of a write to 8'h20 (data 16'h1111), pulse mem_wr with address 8'h21 → only 8'h20 is written; reading 8'h21 returns its prior value.
  - Simultaneous mem_rd+mem_wr → treated as a write, mem_bus_en stays 0.
- Zero-wait build, WAIT_CYCLES=0: a read sampled at edge E → mem_ready high in the cycle after E; back-to-back requests complete every 2 cycles.
- Reset mid-access: write 16'hBEEF to 8'h30 (previously 16'h0001), assert nrst=0 during WAIT → no ready pulse; a later read of 8'h30 returns 16'h0001.
- MEM_WRPROT_EN defined, PROT_BASE=8'hF0:
  - Write 16'hDEAD to 8'hF4 → wr_err=1 with mem_ready; a read of 8'hF4 returns its prior value.
  - Write to 8'hEF → wr_err=0 and the data commits.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory with programmable wait states and a one-cycle ready pulse.
// Optional write protection of the top address range is enabled by defining MEM_WRPROT_EN.
module mem_responder #(
  parameter int                 ADDR_W      = 8,
  parameter int                 DATA_W      = 16,
  parameter int                 WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0]  PROT_BASE   = 8'hF0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_bus_en,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              wr_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_wr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              bus_en_q;
  logic              ready_q;
  logic              busy_q;
  logic              wr_err_q;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              req_d;
  logic              enter_resp_d;
  logic [ADDR_W-1:0] acc_addr_d;
  logic [DATA_W-1:0] acc_data_d;
  logic              acc_wr_d;
  logic              prot_hit_d;
  logic              commit_wr_d;

  // A zero-wait access commits straight from the request inputs; otherwise from the latched copy.
  always_comb begin
    req_d        = mem_rd || mem_wr;
    enter_resp_d = 1'b0;
    acc_addr_d   = addr_q;
    acc_data_d   = wdata_q;
    acc_wr_d     = op_wr_q;
    if (state_q == S_IDLE) begin
      acc_addr_d   = address;
      acc_data_d   = wr_data;
      acc_wr_d     = mem_wr;
      enter_resp_d = req_d && (WAIT_CYCLES == 0);
    end else if (state_q == S_WAIT) begin
      enter_resp_d = (cnt_q == 4'd0);
    end
  end

`ifdef MEM_WRPROT_EN
  assign prot_hit_d = (acc_addr_d >= PROT_BASE);
`else
  // Protection disabled: the comparison is masked so no write is ever blocked.
  assign prot_hit_d = 1'b0 & (acc_addr_d >= PROT_BASE);
`endif

  assign commit_wr_d = enter_resp_d && acc_wr_d && !prot_hit_d;

  // Array write is gated by nrst so a reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (nrst && commit_wr_d) begin
      mem_q[acc_addr_d] <= acc_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      rd_data_q <= '0;
      bus_en_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      ready_q  <= 1'b0;
      bus_en_q <= 1'b0;
      wr_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_d) begin
            addr_q  <= address;
            wdata_q <= wr_data;
            op_wr_q <= mem_wr;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (enter_resp_d) begin
        ready_q  <= 1'b1;
        bus_en_q <= !acc_wr_d;
        wr_err_q <= acc_wr_d && prot_hit_d;
        if (!acc_wr_d) begin
          rd_data_q <= mem_q[acc_addr_d];
        end
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign mem_bus_en = bus_en_q;
  assign mem_ready  = ready_q;
  assign mem_busy   = busy_q;
`ifdef MEM_WRPROT_EN
  assign wr_err     = wr_err_q;
`else
  assign wr_err     = 1'b0 & wr_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a 2-wait instance and a zero-wait instance share clk/nrst.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;

  logic [7:0]  address = '0, address0 = '0;
  logic        mem_rd = 1'b0, mem_rd0 = 1'b0;
  logic        mem_wr = 1'b0, mem_wr0 = 1'b0;
  logic [15:0] wr_data = '0, wr_data0 = '0;
  logic [15:0] rd_data, rd_data0;
  logic        mem_bus_en, mem_bus_en0;
  logic        mem_ready, mem_ready0;
  logic        mem_busy, mem_busy0;
  logic        wr_err, wr_err0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2), .PROT_BASE(8'hF0)) dut (
    .clk(clk), .nrst(nrst), .address(address), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .wr_data(wr_data), .rd_data(rd_data), .mem_bus_en(mem_bus_en),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .wr_err(wr_err)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0), .PROT_BASE(8'hF0)) dut0 (
    .clk(clk), .nrst(nrst), .address(address0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
    .wr_data(wr_data0), .rd_data(rd_data0), .mem_bus_en(mem_bus_en0),
    .mem_ready(mem_ready0), .mem_busy(mem_busy0), .wr_err(wr_err0)
  );

  // One request, then observe 8 cycles; lat = cycle index (1 = cycle after the sampling edge).
  task automatic access(input bit sel, input logic wr, input logic rd, input logic [7:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rdv,
                        output logic ben, output logic werr, output int nready, output int nben);
    logic rdy, be;
    @(negedge clk);
    if (sel) begin mem_wr0 = wr; mem_rd0 = rd; address0 = a; wr_data0 = d; end
    else     begin mem_wr  = wr; mem_rd  = rd; address  = a; wr_data  = d; end
    @(posedge clk);
    #1;
    mem_wr = 1'b0; mem_rd = 1'b0; mem_wr0 = 1'b0; mem_rd0 = 1'b0;
    lat = -1; nready = 0; nben = 0; rdv = 'x; ben = 1'bx; werr = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy = sel ? mem_ready0 : mem_ready;
      be  = sel ? mem_bus_en0 : mem_bus_en;
      if (rdy) begin
        nready++;
        if (lat < 0) begin
          lat  = c;
          rdv  = sel ? rd_data0 : rd_data;
          ben  = be;
          werr = sel ? wr_err0 : wr_err;
        end
      end
      if (be) nben++;
    end
    $display("txn dut%0d wr=%0b rd=%0b addr=%h data=%h lat=%0d rd_data=%h bus_en=%0b wr_err=%0b",
             sel ? 0 : 2, wr, rd, a, d, lat, rdv, ben, werr);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
    checks++; if ({mem_ready, mem_busy, mem_bus_en, wr_err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {mem_ready, mem_busy, mem_bus_en, wr_err}); end
    checks++; if ({rd_data0, mem_ready0, mem_busy0, mem_bus_en0} !== 19'b0) begin
      errors++; $display("FAIL reset_dut0 got %h exp 0", {rd_data0, mem_ready0, mem_busy0, mem_bus_en0}); end
    nrst = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_write_read();
    int lat, nr, nb; logic [15:0] rv; logic be, we;
    access(1'b0, 1'b1, 1'b0, 8'h10, 16'hA55A, lat, rv, be, we, nr, nb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
    checks++; if (nr !== 1) begin errors++; $display("FAIL wr_ready_count got %0d exp 1", nr); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL wr_bus_en got %0d exp 0", nb); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL wr_rd_data_hold got %h exp 0000", rd_data); end
    access(1'b0, 1'b0, 1'b1, 8'h10, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (rv !== 16'hA55A) begin errors++; $display("FAIL rd_data got %h exp a55a", rv); end
    checks++; if (be !== 1'b1 || nb !== 1) begin errors++; $display("FAIL rd_bus_en got %b/%0d exp 1/1", be, nb); end
    checks++; if (rd_data !== 16'hA55A) begin errors++; $display("FAIL rd_data_hold got %h exp a55a", rd_data); end
  endtask

  task automatic test_busy_priority();
    int lat, nr, nb; logic [15:0] rv; logic be, we;
    access(1'b0, 1'b1, 1'b0, 8'h21, 16'h2121, lat, rv, be, we, nr, nb);
    @(negedge clk);
    mem_wr = 1'b1; address = 8'h20; wr_data = 16'h1111;
    @(posedge clk);
    #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL busy_in_wait got %b exp 1", mem_busy); end
    mem_wr = 1'b1; address = 8'h21; wr_data = 16'h9999;
    @(negedge clk);
    @(negedge clk);
    mem_wr = 1'b0;
    repeat (4) @(negedge clk);
    $display("txn busy write 20 with ignored write to 21");
    access(1'b0, 1'b0, 1'b1, 8'h21, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv !== 16'h2121) begin errors++; $display("FAIL busy_ignored got %h exp 2121", rv); end
    access(1'b0, 1'b0, 1'b1, 8'h20, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv !== 16'h1111) begin errors++; $display("FAIL busy_committed got %h exp 1111", rv); end
    access(1'b0, 1'b1, 1'b1, 8'h22, 16'h7777, lat, rv, be, we, nr, nb);
    checks++; if (nb !== 0 || nr !== 1) begin errors++; $display("FAIL both_bus_en got %0d/%0d exp 0/1", nb, nr); end
    checks++; if (rd_data !== 16'h1111) begin errors++; $display("FAIL both_rd_hold got %h exp 1111", rd_data); end
    access(1'b0, 1'b0, 1'b1, 8'h22, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv !== 16'h7777) begin errors++; $display("FAIL both_is_write got %h exp 7777", rv); end
  endtask

  task automatic test_zero_wait();
    int lat, nr, nb; logic [15:0] rv; logic be, we;
    logic [5:0] pat;
    access(1'b1, 1'b1, 1'b0, 8'h05, 16'h5A5A, lat, rv, be, we, nr, nb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zw_wr_latency got %0d exp 1", lat); end
    access(1'b1, 1'b0, 1'b1, 8'h05, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (lat !== 1 || rv !== 16'h5A5A) begin errors++; $display("FAIL zw_read got %0d/%h exp 1/5a5a", lat, rv); end
    @(negedge clk);
    mem_rd0 = 1'b1; address0 = 8'h05;
    @(posedge clk);
    pat = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat[c] = mem_ready0;
    end
    mem_rd0 = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn zero-wait back-to-back reads ready pattern %b", pat);
    checks++; if (pat !== 6'b010101) begin errors++; $display("FAIL zw_back_to_back got %b exp 010101", pat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    @(negedge clk);
    mem_rd = 1'b1; address = 8'h10;
    @(posedge clk);
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pat[c] = mem_ready;
    end
    mem_rd = 1'b0;
    repeat (4) @(negedge clk);
    $display("txn 2-wait back-to-back reads ready pattern %b", pat);
    checks++; if (pat !== 8'b01000100) begin errors++; $display("FAIL b2b_period got %b exp 01000100", pat); end
  endtask

  task automatic test_reset_mid_access();
    int lat, nr, nb; logic [15:0] rv; logic be, we;
    int seen;
    access(1'b0, 1'b1, 1'b0, 8'h30, 16'h0001, lat, rv, be, we, nr, nb);
    @(negedge clk);
    mem_wr = 1'b1; address = 8'h30; wr_data = 16'hBEEF;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    nrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    $display("txn reset during write of beef to 30");
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ready got %0d exp 0", seen); end
    access(1'b0, 1'b0, 1'b1, 8'h30, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv !== 16'h0001) begin errors++; $display("FAIL abort_no_commit got %h exp 0001", rv); end
  endtask

  task automatic test_wrprot();
    int lat, nr, nb; logic [15:0] rv; logic be, we;
    access(1'b0, 1'b1, 1'b0, 8'hF4, 16'hDEAD, lat, rv, be, we, nr, nb);
    checks++; if (lat !== 3 || nr !== 1) begin errors++; $display("FAIL prot_timing got %0d/%0d exp 3/1", lat, nr); end
`ifdef MEM_WRPROT_EN
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL prot_wr_err got %b exp 1", we); end
    access(1'b0, 1'b0, 1'b1, 8'hF4, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv === 16'hDEAD) begin errors++; $display("FAIL prot_blocked got %h exp not dead", rv); end
`else
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL noprot_wr_err got %b exp 0", we); end
    access(1'b0, 1'b0, 1'b1, 8'hF4, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv !== 16'hDEAD) begin errors++; $display("FAIL noprot_commit got %h exp dead", rv); end
`endif
    access(1'b0, 1'b1, 1'b0, 8'hEF, 16'hCAFE, lat, rv, be, we, nr, nb);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL below_base_wr_err got %b exp 0", we); end
    access(1'b0, 1'b0, 1'b1, 8'hEF, 16'h0, lat, rv, be, we, nr, nb);
    checks++; if (rv !== 16'hCAFE) begin errors++; $display("FAIL below_base_commit got %h exp cafe", rv); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_busy_priority();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid_access();
    test_wrprot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
